// File: rtl/tt_um_count_checker.sv
// Receive-side checker for an incoming free-running 8-bit count stream.
// Locks onto the stream after LOCK_LEN consecutive +1 steps, counts
// sequence breaks seen while locked (saturating at 255) and reports
// status on the upper bidirectional pins.
//
// Sample interface: uio_in[0] (sample_en) is a valid-only strobe with no
// ready/backpressure. Every clk edge with sample_en=1 consumes ui_in as
// one sample. Edges with sample_en=0 consume nothing: all state holds and
// only the one-cycle wrap pulse drops. clr_err (uio_in[1]) acts on any
// edge, whether or not a sample is taken.
module tt_um_count_checker #(
    parameter int LOCK_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena
);

    // The run counter is 4 bits, so lock lengths outside 1..15 are rejected.
    generate
        if (LOCK_LEN < 1 || LOCK_LEN > 15) begin : g_bad_lock_len
            $error("tt_um_count_checker: LOCK_LEN must be within 1..15");
        end
    endgenerate

    localparam logic [3:0] LOCK_LEN_4 = 4'(LOCK_LEN);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] prev_q, prev_d;
    logic [3:0] run_q, run_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       err_sticky_q, err_sticky_d;
    logic       wrap_pulse_q, wrap_pulse_d;

    logic       sample_en;
    logic       clr_err;
    logic       match;
    logic [7:0] prev_inc;
    logic [3:0] run_inc;
    logic       seq_err;

    // ena and the upper uio_in bits carry no meaning for this tile.
    logic       unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in[7:2]};

    assign sample_en = uio_in[0];
    assign clr_err   = uio_in[1];
    assign prev_inc  = prev_q + 8'd1;
    assign run_inc   = run_q + 4'd1;
    assign match     = (ui_in == prev_inc);

    // Next-state logic for the lock FSM, the previous sample and the run length.
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        run_d        = run_q;
        wrap_pulse_d = 1'b0;
        seq_err      = 1'b0;
        if (sample_en) begin
            prev_d = ui_in;
            case (state_q)
                SEARCH: begin
                    run_d   = 4'd0;
                    state_d = ACQUIRE;
                end
                ACQUIRE: begin
                    if (match) begin
                        if (run_inc == LOCK_LEN_4) begin
                            run_d   = 4'd0;
                            state_d = LOCKED;
                        end else begin
                            run_d = run_inc;
                        end
                    end else begin
                        run_d = 4'd0;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        wrap_pulse_d = (prev_q == 8'hFF);
                    end else begin
                        seq_err = 1'b1;
                        run_d   = 4'd0;
                        state_d = ACQUIRE;
                    end
                end
                default: begin
                    run_d   = 4'd0;
                    state_d = SEARCH;
                end
            endcase
        end
    end

    // Error counter and sticky flag; a clear on the same edge beats an error.
    always_comb begin
        err_cnt_d    = err_cnt_q;
        err_sticky_d = err_sticky_q;
        if (seq_err) begin
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
            err_sticky_d = 1'b1;
        end
        if (clr_err) begin
            err_cnt_d    = 8'd0;
            err_sticky_d = 1'b0;
        end
    end

    // State register; reset drops lock and all counts immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SEARCH;
            prev_q       <= 8'd0;
            run_q        <= 4'd0;
            err_cnt_q    <= 8'd0;
            err_sticky_q <= 1'b0;
            wrap_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            run_q        <= run_d;
            err_cnt_q    <= err_cnt_d;
            err_sticky_q <= err_sticky_d;
            wrap_pulse_q <= wrap_pulse_d;
        end
    end

    // Outputs are pure decodes of registers, so nothing flows from ui_in
    // to the pins without passing through a flop.
    always_comb begin
        uo_out  = err_cnt_q;
        uio_out = {(err_cnt_q == 8'hFF), wrap_pulse_q, err_sticky_q,
                   (state_q == LOCKED), 4'b0000};
        uio_oe  = 8'hF0;
    end

endmodule

// File: tb/tb_tt_um_count_checker.sv
// Directed bench for tt_um_count_checker with hand-computed expectations.
// uio_out status nibble: bit4 locked, bit5 err_sticky, bit6 wrap_pulse,
// bit7 err_sat.
module tb_tt_um_count_checker;

  logic       clk;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ena;

  int n_checks;
  int n_pass;

  tt_um_count_checker #(.LOCK_LEN(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // checker
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  // driver: present inputs, let one rising edge consume them, settle 1 time unit
  task automatic cycle(input logic [7:0] v, input logic en, input logic clr);
    ui_in  = v;
    uio_in = {6'b0, clr, en};
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [7:0] v);
    cycle(v, 1'b1, 1'b0);
  endtask

  // reset pulse applied away from the clock edge
  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  // SEARCH sample then four +1 steps -> LOCKED
  task automatic lock_on(input logic [7:0] start);
    for (int i = 0; i < 5; i++) feed(start + 8'(i));
  endtask

  logic [7:0] v;
  logic [7:0] exp_err;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    ena      = 1'b1;
    ui_in    = 8'd0;
    uio_in   = 8'd0;
    rst_n    = 1'b0;
    #2;
    check("reset_uo_out", uo_out, 8'h00);
    check("reset_uio_out", uio_out, 8'h00);
    check("uio_oe", uio_oe, 8'hF0);
    #10;
    rst_n = 1'b1;

    // acquire lock on 10..14
    feed(8'd10);
    check("search_not_locked", uio_out, 8'h00);
    feed(8'd11); feed(8'd12); feed(8'd13);
    check("acq_run3_not_locked", uio_out, 8'h00);
    feed(8'd14);
    check("locked_after_14", uio_out, 8'h10);
    check("no_err_after_lock", uo_out, 8'h00);

    // wrap 255 -> 0
    do_reset();
    lock_on(8'd250);
    check("locked_at_254", uio_out, 8'h10);
    feed(8'd255);
    check("no_wrap_at_255", uio_out, 8'h10);
    feed(8'd0);
    check("wrap_pulse_after_0", uio_out, 8'h50);
    cycle(8'h99, 1'b0, 1'b0);
    check("wrap_clears_en0", uio_out, 8'h10);
    feed(8'd1);
    check("still_locked_after_1", uio_out, 8'h10);
    check("no_err_after_wrap", uo_out, 8'h00);

    // single error and relock
    do_reset();
    lock_on(8'd16);
    feed(8'd22);
    check("err1_count", uo_out, 8'd1);
    check("err1_status", uio_out, 8'h20);
    feed(8'd23); feed(8'd24); feed(8'd25);
    check("relock_pending", uio_out, 8'h20);
    feed(8'd26);
    check("relocked", uio_out, 8'h30);
    check("err_count_held", uo_out, 8'd1);

    // drive the error counter through saturation to 300 errors
    v = 8'd26;
    exp_err = 8'd1;
    for (int e = 2; e <= 300; e++) begin
      v = v + 8'd2;
      feed(v);
      if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
      if (e == 254) begin
        check("err254_count", uo_out, exp_err);
        check("err254_not_sat", uio_out, 8'h20);
      end
      if (e == 255) begin
        check("err255_count", uo_out, exp_err);
        check("err255_sat", uio_out, 8'hA0);
      end
      for (int k = 0; k < 4; k++) begin
        v = v + 8'd1;
        feed(v);
      end
    end
    check("err300_count", uo_out, 8'd255);
    check("err300_status", uio_out, 8'hB0);

    // clear on the same edge as an error: clear wins, state still drops lock
    v = v + 8'd2;
    cycle(v, 1'b1, 1'b1);
    check("clr_with_err_count", uo_out, 8'd0);
    check("clr_with_err_status", uio_out, 8'h00);

    // sample_en gating: only enabled samples are checked
    cycle(v + 8'd1, 1'b1, 1'b0);
    cycle(8'h77, 1'b0, 1'b0);
    cycle(8'h03, 1'b0, 1'b0);
    cycle(v + 8'd2, 1'b1, 1'b0);
    cycle(8'hC4, 1'b0, 1'b0);
    cycle(v + 8'd3, 1'b1, 1'b0);
    check("gated_run3_not_locked", uio_out, 8'h00);
    cycle(v + 8'd4, 1'b1, 1'b0);
    check("gated_locked", uio_out, 8'h10);
    cycle(8'h00, 1'b0, 1'b0);
    cycle(v + 8'd5, 1'b1, 1'b0);
    cycle(8'h5A, 1'b0, 1'b0);
    cycle(v + 8'd6, 1'b1, 1'b0);
    check("gated_no_errors", uo_out, 8'd0);
    check("gated_still_locked", uio_out, 8'h10);

    // clr_err works without a sample
    v = v + 8'd6;
    feed(v + 8'd9);
    check("pre_clr_count", uo_out, 8'd1);
    cycle(8'h00, 1'b0, 1'b1);
    check("clr_en0_count", uo_out, 8'd0);
    check("clr_en0_status", uio_out, 8'h00);

    // build up three errors while locked, then reset asynchronously
    do_reset();
    v = 8'd100;
    lock_on(v);
    v = v + 8'd4;
    for (int e = 0; e < 3; e++) begin
      v = v + 8'd3;
      feed(v);
      for (int k = 0; k < 4; k++) begin
        v = v + 8'd1;
        feed(v);
      end
    end
    check("pre_rst_count", uo_out, 8'd3);
    check("pre_rst_status", uio_out, 8'h30);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_uo_out", uo_out, 8'h00);
    check("async_rst_uio_out", uio_out, 8'h00);
    #2;
    rst_n = 1'b1;
    feed(8'd40);
    check("post_rst_search", uio_out, 8'h00);
    feed(8'd41); feed(8'd42); feed(8'd43);
    check("post_rst_acquire", uio_out, 8'h00);
    feed(8'd44);
    check("post_rst_locked", uio_out, 8'h10);
    check("post_rst_count", uo_out, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
